// File: rtl/ws2812_frame_ctrl.sv
// Frame scheduler and double-buffered pixel store feeding a ws2812 strip driver.
// Banks swap only on LATCH entry so a frame is never streamed from a half-updated bank.
module ws2812_frame_ctrl #(
    parameter int NUM_LEDS     = 8,
    parameter int ADDR_BITS    = 3,
    parameter int SYSTEM_CLOCK = 48000000,
    parameter int REFRESH_HZ   = 100,
    parameter int LATCH_CYCLES = 2400
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [23:0]          wr_rgb,
    input  logic                 commit,
    output logic                 wr_ready,
    output logic                 swap_done,
    output logic                 drv_reset,
    input  logic [ADDR_BITS-1:0] drv_address,
    input  logic                 drv_new_address,
    output logic [23:0]          pix_rgb,
    output logic                 frame_start,
    output logic [15:0]          frame_count
);

    localparam int FRAME_CYCLES = SYSTEM_CLOCK / REFRESH_HZ;
    localparam int TIMER_BITS   = $clog2(FRAME_CYCLES + 1);
    localparam int LATCH_BITS   = $clog2(LATCH_CYCLES + 1);
    localparam int PIX_BITS     = $clog2(NUM_LEDS + 1);
    localparam int IDX_BITS     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(FRAME_CYCLES - 1);
    localparam logic [LATCH_BITS-1:0] LATCH_LAST = LATCH_BITS'(LATCH_CYCLES - 1);
    localparam logic [PIX_BITS-1:0]   PIX_LAST   = PIX_BITS'(NUM_LEDS - 1);
    localparam logic [ADDR_BITS:0]    ADDR_LIMIT = (ADDR_BITS + 1)'(NUM_LEDS);

    typedef enum logic [1:0] {LATCH, STREAM, WAIT} state_t;

    state_t                state;
    state_t                next_state;
    logic [TIMER_BITS-1:0] frame_timer;
    logic [LATCH_BITS-1:0] latch_cnt;
    logic [PIX_BITS-1:0]   pix_cnt;
    logic                  frame_expired;
    logic                  pending;
    logic                  active_bank;
    logic                  latch_entry;
    logic                  timer_last;
    logic                  wr_valid;
    logic                  rd_valid;
    logic [IDX_BITS-1:0]   wr_idx;
    logic [IDX_BITS-1:0]   rd_idx;
    logic [23:0]           bank [2][NUM_LEDS];

    assign timer_last  = (frame_timer == TIMER_LAST);
    assign latch_entry = (state != LATCH) && (next_state == LATCH);
    assign wr_ready    = !pending;
    assign wr_valid    = wr_en && !pending && ({1'b0, wr_addr} < ADDR_LIMIT);
    assign rd_valid    = ({1'b0, drv_address} < ADDR_LIMIT);
    assign wr_idx      = wr_addr[IDX_BITS-1:0];
    assign rd_idx      = drv_address[IDX_BITS-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LATCH;
        else       state <= next_state;
    end

    // An overrun stream sets frame_expired so WAIT leaves immediately instead of waiting a full wrap.
    always_comb begin
        next_state = state;
        case (state)
            LATCH:   if (latch_cnt == LATCH_LAST && enable) next_state = STREAM;
            STREAM:  if (drv_new_address && pix_cnt == PIX_LAST) next_state = WAIT;
            WAIT:    if (timer_last || frame_expired) next_state = LATCH;
            default: next_state = LATCH;
        endcase
    end

    always_comb begin
        drv_reset = (state == LATCH);
        pix_rgb   = rd_valid ? bank[active_bank][rd_idx] : 24'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_timer   <= '0;
            latch_cnt     <= '0;
            pix_cnt       <= '0;
            frame_expired <= 1'b0;
            frame_start   <= 1'b0;
            frame_count   <= '0;
            swap_done     <= 1'b0;
            pending       <= 1'b0;
            active_bank   <= 1'b0;
        end else begin
            frame_start <= (state == LATCH) && (next_state == STREAM);
            if ((state == LATCH) && (next_state == STREAM)) frame_count <= frame_count + 16'd1;

            if (latch_entry || timer_last) frame_timer <= '0;
            else                           frame_timer <= frame_timer + 1'b1;

            if (latch_entry)                          frame_expired <= 1'b0;
            else if (timer_last && state != LATCH)    frame_expired <= 1'b1;

            if (state != LATCH)               latch_cnt <= '0;
            else if (latch_cnt != LATCH_LAST) latch_cnt <= latch_cnt + 1'b1;

            if (state != STREAM)      pix_cnt <= '0;
            else if (drv_new_address) pix_cnt <= pix_cnt + 1'b1;

            swap_done <= latch_entry && pending;
            if (latch_entry && pending) begin
                active_bank <= ~active_bank;
                pending     <= 1'b0;
            end else if (commit && !pending) begin
                pending <= 1'b1;
            end
        end
    end

    // Writes always target the back bank; a same-cycle commit still sees this write land first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NUM_LEDS; i++)
                    bank[b][i] <= 24'h0;
        end else if (wr_valid) begin
            bank[~active_bank][wr_idx] <= wr_rgb;
        end
    end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Randomised bench for ws2812_frame_ctrl against a frame-level model of the banks and schedule.
module tb_ws2812_frame_ctrl;

    localparam int NL = 4;
    localparam int FC = 100;
    localparam int LC = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [23:0] wr_rgb = '0;
    logic        commit = 1'b0;
    logic        wr_ready;
    logic        swap_done;
    logic        drv_reset;
    logic [2:0]  drv_address = '0;
    logic        drv_new_address = 1'b0;
    logic [23:0] pix_rgb;
    logic        frame_start;
    logic [15:0] frame_count;

    int tests = 0;
    int fails = 0;
    int t = 0;
    logic [23:0] m_front [NL];
    logic [23:0] m_back  [NL];
    bit          m_pend;
    int          m_frames;

    ws2812_frame_ctrl #(
        .NUM_LEDS(NL), .ADDR_BITS(3), .SYSTEM_CLOCK(1000), .REFRESH_HZ(10), .LATCH_CYCLES(LC)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_rgb(wr_rgb), .commit(commit), .wr_ready(wr_ready), .swap_done(swap_done),
        .drv_reset(drv_reset), .drv_address(drv_address), .drv_new_address(drv_new_address),
        .pix_rgb(pix_rgb), .frame_start(frame_start), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < NL; i++) begin
            m_front[i] = '0;
            m_back[i]  = '0;
        end
        m_pend   = 0;
        m_frames = 0;
        t        = 0;
    endtask

    // One clock: drive driver + user inputs, check the read path, then check the edge's effects.
    task automatic step(input logic we, input logic [2:0] a, input logic [23:0] d, input logic cm);
        int ph, k;
        logic [23:0] exp_pix;
        bit rdy, swap_now, frame_now;
        logic [23:0] tmp;
        ph = t % FC;
        k  = ph - LC;
        if (ph >= LC && k < 5 * NL) begin
            drv_address     = 3'(k / 5);
            drv_new_address = (k % 5 == 4);
        end else begin
            drv_address     = 3'($urandom_range(0, 7));
            drv_new_address = 1'($urandom_range(0, 1));
        end
        wr_en = we; wr_addr = a; wr_rgb = d; commit = cm;
        #1;
        exp_pix = (int'(drv_address) < NL) ? m_front[drv_address] : 24'h0;
        tests++;
        if (pix_rgb !== exp_pix) begin
            fails++;
            $display("[TB] FAIL pix_rgb t=%0d addr=%0d got %h expected %h", t, drv_address, pix_rgb, exp_pix);
        end
        @(posedge clk);
        #1;
        t++;
        rdy = !m_pend;
        if (we && rdy && int'(a) < NL) m_back[a] = d;
        swap_now = (t % FC == 0) && m_pend;
        if (swap_now) begin
            for (int i = 0; i < NL; i++) begin
                tmp = m_front[i]; m_front[i] = m_back[i]; m_back[i] = tmp;
            end
            m_pend = 0;
        end else if (cm && rdy) begin
            m_pend = 1;
        end
        frame_now = (t % FC == LC);
        if (frame_now) m_frames++;
        tests += 5;
        if (drv_reset !== ((t % FC) < LC)) begin
            fails++; $display("[TB] FAIL drv_reset t=%0d got %b expected %b", t, drv_reset, (t % FC) < LC);
        end
        if (frame_start !== frame_now) begin
            fails++; $display("[TB] FAIL frame_start t=%0d got %b expected %b", t, frame_start, frame_now);
        end
        if (swap_done !== swap_now) begin
            fails++; $display("[TB] FAIL swap_done t=%0d got %b expected %b", t, swap_done, swap_now);
        end
        if (wr_ready !== !m_pend) begin
            fails++; $display("[TB] FAIL wr_ready t=%0d got %b expected %b", t, wr_ready, !m_pend);
        end
        if (frame_count !== 16'(m_frames)) begin
            fails++; $display("[TB] FAIL frame_count t=%0d got %0d expected %0d", t, frame_count, m_frames);
        end
        wr_en = 1'b0; commit = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (t < target) step(1'b0, 3'd0, 24'h0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        tests += 5;
        if (drv_reset !== 1'b1) begin fails++; $display("[TB] FAIL %s drv_reset got %b expected 1", tag, drv_reset); end
        if (wr_ready !== 1'b1) begin fails++; $display("[TB] FAIL %s wr_ready got %b expected 1", tag, wr_ready); end
        if (swap_done !== 1'b0) begin fails++; $display("[TB] FAIL %s swap_done got %b expected 0", tag, swap_done); end
        if (frame_start !== 1'b0) begin fails++; $display("[TB] FAIL %s frame_start got %b expected 0", tag, frame_start); end
        if (frame_count !== 16'd0) begin fails++; $display("[TB] FAIL %s frame_count got %0d expected 0", tag, frame_count); end
        for (int i = 0; i < 8; i++) begin
            drv_address = 3'(i);
            #1;
            tests++;
            if (pix_rgb !== 24'h0) begin
                fails++; $display("[TB] FAIL %s pix_rgb addr=%0d got %h expected 0", tag, i, pix_rgb);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b1; wr_en = 1'b0; commit = 1'b0; drv_new_address = 1'b0;
        repeat (2) @(posedge clk);
        check_reset_values("reset_hold");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        run_to(FC + 1);
    endtask

    task automatic test_swap();
        run_to(FC + 12);
        step(1'b1, 3'd2, 24'hFF0000, 1'b0);
        step(1'b0, 3'd0, 24'h0, 1'b1);
        run_to(2 * FC + 30);
    endtask

    task automatic test_double_commit();
        step(1'b1, 3'd1, 24'h123456, 1'b1);
        step(1'b0, 3'd0, 24'h0, 1'b1);
        step(1'b1, 3'd3, 24'hABCDEF, 1'b0);
        step(1'b1, 3'd6, 24'h777777, 1'b0);
        run_to(4 * FC + 30);
    endtask

    task automatic test_write_commit_same();
        step(1'b1, 3'd0, 24'h00FF00, 1'b1);
        run_to(5 * FC + 30);
    endtask

    task automatic test_random();
        while (t < 11 * FC) begin
            step(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 24'($urandom),
                 1'($urandom_range(0, 39) == 0));
        end
    endtask

    task automatic test_enable_park();
        do_reset();
        run_to(LC + 3);
        enable = 1'b0;
        run_to(FC);
        for (int i = 0; i < 150; i++) begin
            drv_address = 3'($urandom_range(0, 7));
            drv_new_address = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            tests += 3;
            if (drv_reset !== 1'b1) begin fails++; $display("[TB] FAIL park drv_reset cyc=%0d got %b expected 1", i, drv_reset); end
            if (frame_start !== 1'b0) begin fails++; $display("[TB] FAIL park frame_start cyc=%0d got %b expected 0", i, frame_start); end
            if (frame_count !== 16'd1) begin fails++; $display("[TB] FAIL park frame_count cyc=%0d got %0d expected 1", i, frame_count); end
        end
        drv_new_address = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        #1;
        tests += 3;
        if (frame_start !== 1'b1) begin fails++; $display("[TB] FAIL resume frame_start got %b expected 1", frame_start); end
        if (drv_reset !== 1'b0) begin fails++; $display("[TB] FAIL resume drv_reset got %b expected 0", drv_reset); end
        if (frame_count !== 16'd2) begin fails++; $display("[TB] FAIL resume frame_count got %0d expected 2", frame_count); end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        run_to(LC + 2);
        step(1'b1, 3'd0, 24'hA5A5A5, 1'b1);
        run_to(FC + LC + 2);
        step(1'b1, 3'd1, 24'h5A5A5A, 1'b1);
        run_to(FC + LC + 9);
        drv_address = 3'd1;
        drv_new_address = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("mid_stream_reset");
        drv_new_address = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        run_to(FC + 30);
    endtask

    initial begin
        test_reset();
        test_swap();
        test_double_commit();
        test_write_commit_same();
        test_random();
        test_enable_park();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
